// File: rtl/io_bridge_pkg.sv
// rtl/io_bridge_pkg.sv - shared types and constants for the CPU-to-peripheral bridge
package io_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [31:0] DEV0_BASE_DEFAULT = 32'h0000_7F00;
    localparam logic [31:0] DEV1_BASE_DEFAULT = 32'h0000_7F10;

    localparam int WORD_OFF_W = 2;
    localparam int HW_INT_W   = 6;
    localparam int CNT_W      = 8;

endpackage

// File: rtl/io_bridge_if.sv
// rtl/io_bridge_if.sv - CPU load/store side and device bus side of the bridge
interface io_bridge_if;
    import io_bridge_pkg::*;

    logic [31:0]           cpu_addr;
    logic [31:0]           cpu_wdata;
    logic                  cpu_we;
    logic                  cpu_re;
    logic [31:0]           cpu_rd;
    logic                  cpu_stall;
    logic                  cpu_err;
    logic [WORD_OFF_W-1:0] dev_addr;
    logic [31:0]           dev_wdata;
    logic                  dev0_sel;
    logic                  dev1_sel;
    logic                  dev_we;
    logic [31:0]           dev0_rdata;
    logic [31:0]           dev1_rdata;
    logic                  dev0_ready;
    logic                  dev1_ready;
    logic                  dev0_irq;
    logic                  dev1_irq;
    logic [HW_INT_W-1:0]   hw_int;

    // bridge view
    modport master (
        input  cpu_addr, cpu_wdata, cpu_we, cpu_re,
        input  dev0_rdata, dev1_rdata, dev0_ready, dev1_ready, dev0_irq, dev1_irq,
        output cpu_rd, cpu_stall, cpu_err,
        output dev_addr, dev_wdata, dev0_sel, dev1_sel, dev_we, hw_int
    );

    // CPU plus devices view
    modport slave (
        output cpu_addr, cpu_wdata, cpu_we, cpu_re,
        output dev0_rdata, dev1_rdata, dev0_ready, dev1_ready, dev0_irq, dev1_irq,
        input  cpu_rd, cpu_stall, cpu_err,
        input  dev_addr, dev_wdata, dev0_sel, dev1_sel, dev_we, hw_int
    );

endinterface

// File: rtl/io_addr_decode.sv
// rtl/io_addr_decode.sv - window match and word-alignment check for the CPU address
module io_addr_decode
    import io_bridge_pkg::*;
#(
    parameter logic [31:0] DEV0_BASE = DEV0_BASE_DEFAULT,
    parameter logic [31:0] DEV1_BASE = DEV1_BASE_DEFAULT
) (
    input  logic [31:0] addr,
    output logic        hit0,
    output logic        hit1,
    output logic        misalign
);

    // word offset bits are routed to the device by the top, not used for matching
    logic unused_offset_bits;
    assign unused_offset_bits = ^addr[3:2];

    assign hit0     = (addr[31:4] == DEV0_BASE[31:4]);
    assign hit1     = (addr[31:4] == DEV1_BASE[31:4]);
    assign misalign = (addr[1:0] != 2'b00);

endmodule

// File: rtl/io_bridge.sv
// rtl/io_bridge.sv - load/store bridge to two peripherals; IO_BRIDGE_IRQ_REG_EN registers hw_int
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter logic [31:0] DEV0_BASE = DEV0_BASE_DEFAULT,
    parameter logic [31:0] DEV1_BASE = DEV1_BASE_DEFAULT,
    parameter int          TIMEOUT   = 15
) (
    input  logic        clk,
    input  logic        reset,
    io_bridge_if.master bus
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    logic hit0, hit1, misalign;
    logic req, hit, ready_sel;
    logic [31:0] rdata_sel;

    state_t                state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic                  err_q, err_n;
    logic [31:0]           rd_q, rd_n;
    logic                  sel0_q, sel0_n;
    logic                  sel1_q, sel1_n;
    logic                  we_q, we_n;
    logic [WORD_OFF_W-1:0] addr_q, addr_n;
    logic [31:0]           wdata_q, wdata_n;

    io_addr_decode #(
        .DEV0_BASE (DEV0_BASE),
        .DEV1_BASE (DEV1_BASE)
    ) u_decode (
        .addr     (bus.cpu_addr),
        .hit0     (hit0),
        .hit1     (hit1),
        .misalign (misalign)
    );

    assign req       = bus.cpu_we | bus.cpu_re;
    assign hit       = (hit0 | hit1) & ~misalign;
    // only the device we selected may complete the access
    assign ready_sel = (sel0_q & bus.dev0_ready) | (sel1_q & bus.dev1_ready);
    assign rdata_sel = sel1_q ? bus.dev1_rdata : bus.dev0_rdata;

    // state and datapath registers; reset drops any transfer in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            err_q   <= 1'b0;
            rd_q    <= '0;
            sel0_q  <= 1'b0;
            sel1_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            err_q   <= err_n;
            rd_q    <= rd_n;
            sel0_q  <= sel0_n;
            sel1_q  <= sel1_n;
            we_q    <= we_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
        end
    end

    // next-state: decode in IDLE, wait for ready or timeout in ACCESS, report in DONE
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        err_n   = err_q;
        rd_n    = rd_q;
        sel0_n  = sel0_q;
        sel1_n  = sel1_q;
        we_n    = we_q;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (hit) begin
                        addr_n  = bus.cpu_addr[3:2];
                        wdata_n = bus.cpu_wdata;
                        sel0_n  = hit0;
                        sel1_n  = hit1 & ~hit0;
                        we_n    = bus.cpu_we;
                        cnt_n   = '0;
                        err_n   = 1'b0;
                        state_n = ST_ACCESS;
                    end else begin
                        err_n   = 1'b1;
                        rd_n    = '0;
                        state_n = ST_DONE;
                    end
                end
            end
            ST_ACCESS: begin
                if (ready_sel) begin
                    rd_n    = we_q ? 32'd0 : rdata_sel;
                    sel0_n  = 1'b0;
                    sel1_n  = 1'b0;
                    we_n    = 1'b0;
                    state_n = ST_DONE;
                end else begin
                    cnt_n = cnt + 1'b1;
                    if (cnt_n == CNT_LIMIT) begin
                        sel0_n  = 1'b0;
                        sel1_n  = 1'b0;
                        we_n    = 1'b0;
                        rd_n    = '0;
                        err_n   = 1'b1;
                        state_n = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                err_n   = 1'b0;
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign bus.cpu_stall = ((state == ST_IDLE) & req) | (state == ST_ACCESS);
    assign bus.cpu_err   = (state == ST_DONE) & err_q;
    assign bus.cpu_rd    = rd_q;
    assign bus.dev0_sel  = sel0_q;
    assign bus.dev1_sel  = sel1_q;
    assign bus.dev_we    = we_q;
    assign bus.dev_addr  = addr_q;
    assign bus.dev_wdata = wdata_q;

`ifdef IO_BRIDGE_IRQ_REG_EN
    logic [HW_INT_W-1:0] hw_int_q;

    // interrupt lines retimed by one cycle before reaching CP0
    always_ff @(posedge clk) begin
        if (reset) begin
            hw_int_q <= '0;
        end else begin
            hw_int_q <= {{(HW_INT_W-2){1'b0}}, bus.dev1_irq, bus.dev0_irq};
        end
    end

    assign bus.hw_int = hw_int_q;
`else
    assign bus.hw_int = {{(HW_INT_W-2){1'b0}}, bus.dev1_irq, bus.dev0_irq};
`endif

endmodule

// File: tb/tb_io_bridge.sv
// tb/tb_io_bridge.sv - self-checking bench for io_bridge
module tb_io_bridge;

    localparam logic [31:0] DEV0_BASE = 32'h0000_7F00;
    localparam logic [31:0] DEV1_BASE = 32'h0000_7F10;
    localparam int          TIMEOUT   = 15;

    logic clk;
    logic reset;

    io_bridge_if bus ();

    io_bridge dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic        chk_en;
    logic        exp_stall, exp_sel0, exp_sel1, exp_err, exp_we, exp_bus_chk;
    logic [1:0]  exp_addr;
    logic [31:0] exp_wdata, exp_rd, prev_rd;
    logic [31:0] cyc;
    logic        irq_force;
    int          stall_run, last_stall_len;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (!irq_force) begin
            bus.dev0_irq = cyc[1];
            bus.dev1_irq = cyc[2];
        end
    endtask

    // one transfer: the model derives the cycle-by-cycle picture from access count
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic we, input logic re, input int dly, input logic oth,
                           input logic [31:0] rd0, input logic [31:0] rd1);
        logic        h0, h1, hit, err;
        int          n;
        logic [31:0] rdv;
        h0  = (addr[31:4] == DEV0_BASE[31:4]) && (addr[1:0] == 2'b00);
        h1  = (addr[31:4] == DEV1_BASE[31:4]) && (addr[1:0] == 2'b00);
        hit = h0 | h1;
        if (!hit) n = 0;
        else if (dly >= 0 && dly < TIMEOUT) n = dly + 1;
        else n = TIMEOUT;
        err = !hit || dly < 0 || dly >= TIMEOUT;
        rdv = (err || we) ? 32'd0 : (h0 ? rd0 : rd1);
        for (int k = 0; k <= n + 1; k++) begin
            tick();
            bus.cpu_addr   = addr;
            bus.cpu_wdata  = wdata;
            bus.cpu_we     = we;
            bus.cpu_re     = re;
            bus.dev0_rdata = rd0;
            bus.dev1_rdata = rd1;
            bus.dev0_ready = h0 ? (k >= 1 && k - 1 == dly) : oth;
            bus.dev1_ready = h1 ? (k >= 1 && k - 1 == dly) : oth;
            exp_stall   = (k <= n);
            exp_sel0    = h0 && k >= 1 && k <= n;
            exp_sel1    = h1 && k >= 1 && k <= n;
            exp_we      = we && k >= 1 && k <= n;
            exp_bus_chk = (k >= 1 && k <= n);
            exp_addr    = addr[3:2];
            exp_wdata   = wdata;
            exp_err     = err && (k == n + 1);
            exp_rd      = (k == n + 1) ? rdv : prev_rd;
        end
        prev_rd = rdv;
        tick();
        bus.cpu_we     = 1'b0;
        bus.cpu_re     = 1'b0;
        bus.dev0_ready = 1'b0;
        bus.dev1_ready = 1'b0;
        exp_stall   = 1'b0;
        exp_sel0    = 1'b0;
        exp_sel1    = 1'b0;
        exp_we      = 1'b0;
        exp_err     = 1'b0;
        exp_bus_chk = 1'b0;
        exp_rd      = prev_rd;
    endtask

    // compare process: every cycle on the falling edge
    initial begin
        logic [5:0] exp_hw;
`ifdef IO_BRIDGE_IRQ_REG_EN
        logic [5:0] hw_model;
        hw_model = '0;
`endif
        stall_run      = 0;
        last_stall_len = 0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("cpu_stall", bus.cpu_stall, exp_stall);
                check("dev0_sel", bus.dev0_sel, exp_sel0);
                check("dev1_sel", bus.dev1_sel, exp_sel1);
                check("cpu_err", bus.cpu_err, exp_err);
                check("dev_we", bus.dev_we, exp_we);
                check("cpu_rd", bus.cpu_rd, exp_rd);
                if (exp_bus_chk) begin
                    check("dev_addr", bus.dev_addr, exp_addr);
                    check("dev_wdata", bus.dev_wdata, exp_wdata);
                end
            end
`ifdef IO_BRIDGE_IRQ_REG_EN
            exp_hw   = hw_model;
            hw_model = reset ? 6'd0 : {4'b0, bus.dev1_irq, bus.dev0_irq};
`else
            exp_hw = {4'b0, bus.dev1_irq, bus.dev0_irq};
`endif
            check("hw_int", bus.hw_int, exp_hw);
            if (bus.cpu_stall) stall_run++;
            else if (stall_run > 0) begin
                last_stall_len = stall_run;
                stall_run      = 0;
            end
        end
    end

    initial begin
        cyc            = '0;
        irq_force      = 1'b0;
        reset          = 1'b1;
        bus.cpu_addr   = '0;
        bus.cpu_wdata  = '0;
        bus.cpu_we     = 1'b0;
        bus.cpu_re     = 1'b0;
        bus.dev0_rdata = '0;
        bus.dev1_rdata = '0;
        bus.dev0_ready = 1'b0;
        bus.dev1_ready = 1'b0;
        bus.dev0_irq   = 1'b0;
        bus.dev1_irq   = 1'b0;
        prev_rd        = '0;
        exp_stall      = 1'b0;
        exp_sel0       = 1'b0;
        exp_sel1       = 1'b0;
        exp_err        = 1'b0;
        exp_we         = 1'b0;
        exp_bus_chk    = 1'b1;
        exp_addr       = '0;
        exp_wdata      = '0;
        exp_rd         = '0;
        chk_en         = 1'b1;

        tick();
        tick();
        reset = 1'b0;
        tick();
        exp_bus_chk = 1'b0;

        run_txn(32'h0000_7F04, 32'h0, 1'b0, 1'b1, 1, 1'b0, 32'hDEADBEEF, 32'h0);
        check("t1_rd_literal", bus.cpu_rd, 32'hDEADBEEF);
        check("t1_stall_len", last_stall_len, 3);

        run_txn(32'h0000_7F20, 32'h0, 1'b0, 1'b1, 0, 1'b0, 32'h1111_1111, 32'h2222_2222);
        check("miss_rd_literal", bus.cpu_rd, 32'h0);
        check("miss_stall_len", last_stall_len, 1);

        run_txn(32'h0000_7F18, 32'h12345678, 1'b1, 1'b0, 0, 1'b0, 32'hAAAA5555, 32'h1111_2222);
        check("store_stall_len", last_stall_len, 2);

        run_txn(32'h0000_7F1C, 32'h0, 1'b0, 1'b1, 3, 1'b1, 32'h5555_AAAA, 32'hCAFEF00D);
        check("dev1_rd_literal", bus.cpu_rd, 32'hCAFEF00D);
        check("dev1_stall_len", last_stall_len, 5);

        run_txn(32'h0000_7F02, 32'h0, 1'b0, 1'b1, 0, 1'b0, 32'h3333_3333, 32'h0);
        check("misalign_rd_literal", bus.cpu_rd, 32'h0);

        run_txn(32'h0000_7F04, 32'h0, 1'b0, 1'b1, 0, 1'b0, 32'h0000_00A5, 32'h0);
        run_txn(32'h0000_7F08, 32'hA5A5_0F0F, 1'b1, 1'b1, 0, 1'b0, 32'h7777_7777, 32'h0);
        check("both_rd_literal", bus.cpu_rd, 32'h0);

        run_txn(32'h0000_7F0C, 32'h0, 1'b0, 1'b1, 14, 1'b0, 32'h0BADCAFE, 32'h0);
        check("late_ready_rd", bus.cpu_rd, 32'h0BADCAFE);
        check("late_ready_stall_len", last_stall_len, 16);

        run_txn(32'h0000_7F00, 32'h0, 1'b0, 1'b1, -1, 1'b0, 32'h9999_9999, 32'h0);
        check("timeout_rd", bus.cpu_rd, 32'h0);
        check("timeout_stall_len", last_stall_len, 16);

        run_txn(32'h0000_7F14, 32'h0, 1'b0, 1'b1, 15, 1'b0, 32'h0, 32'h4444_4444);
        run_txn(32'h0000_8F04, 32'h0, 1'b0, 1'b1, 0, 1'b0, 32'h0, 32'h0);

        // reset in the middle of an access that never completes
        tick();
        bus.cpu_addr  = 32'h0000_7F00;
        bus.cpu_wdata = 32'h0000_0055;
        bus.cpu_re    = 1'b1;
        exp_stall     = 1'b1;
        exp_rd        = prev_rd;
        for (int k = 1; k <= 3; k++) begin
            tick();
            exp_sel0    = 1'b1;
            exp_bus_chk = 1'b1;
            exp_addr    = 2'd0;
            exp_wdata   = 32'h0000_0055;
        end
        tick();
        reset        = 1'b1;
        irq_force    = 1'b1;
        bus.dev0_irq = 1'b1;
        bus.dev1_irq = 1'b0;
        tick();
        reset       = 1'b0;
        bus.cpu_re  = 1'b0;
        prev_rd     = '0;
        exp_stall   = 1'b0;
        exp_sel0    = 1'b0;
        exp_rd      = '0;
        exp_wdata   = '0;
`ifdef IO_BRIDGE_IRQ_REG_EN
        tick();
`endif
        @(negedge clk);
        check("rst_hw_int_literal", bus.hw_int, 32'h1);
        check("rst_sel0_literal", bus.dev0_sel, 32'h0);
        tick();
        exp_bus_chk = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
